// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - three-port PSRAM request arbiter, video priority with burst cap, host/aux round-robin
// Optional busy watchdog enabled by defining PSRAM_ARB_TIMEOUT_EN.
module psram_arbiter #(
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 16,
    parameter int VID_BURST_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk32,
    input  logic              resetn,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        cur_id;
    logic              cur_we;
    logic [3:0]        burst_cnt;
    logic              rr_last2;
    logic              low_pending;
    logic              vid_win;
    logic              grant;
    logic              timeout;
    logic              to_fire;
    logic [1:0]        win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign low_pending = |req[2:1];
    assign vid_win     = req[0] && !((burst_cnt == 4'(VID_BURST_MAX)) && low_pending);
    // The ack cycle is reserved so the acked requester has time to drop req.
    assign grant       = (state == IDLE) && !mem_busy && (|req) && (ack == 3'b000);

    always_comb begin
        win_id = 2'd2;
        if (vid_win) begin
            win_id = 2'd0;
        end else if (req[1] && (!req[2] || rr_last2)) begin
            win_id = 2'd1;
        end
    end

    always_comb begin
        win_we    = we[2];
        win_addr  = addr2;
        win_wdata = wdata2;
        case (win_id)
            2'd0: begin
                win_we    = we[0];
                win_addr  = addr0;
                win_wdata = wdata0;
            end
            2'd1: begin
                win_we    = we[1];
                win_addr  = addr1;
                win_wdata = wdata1;
            end
            default: ;
        endcase
    end

`ifdef PSRAM_ARB_TIMEOUT_EN
    logic [9:0] to_cnt;

    assign timeout = (to_cnt == 10'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk32 or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if ((state == WAIT_BUSY || state == WAIT_DONE) && !timeout) begin
            to_cnt <= to_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk32 or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else begin
            err <= to_fire;
        end
    end
`else
    // Watchdog compiled out: never fires, the FSM waits on busy forever.
    assign timeout = (TIMEOUT_CYCLES < 0);
    assign err     = 1'b0;
`endif

    // A normal completion in WAIT_DONE wins over a coincident timeout.
    assign to_fire = timeout && ((state == WAIT_BUSY) || (state == WAIT_DONE && mem_busy));

    always_ff @(posedge clk32 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cur_id    <= 2'd0;
            cur_we    <= 1'b0;
            burst_cnt <= 4'd0;
            rr_last2  <= 1'b1;
            ack       <= 3'b000;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            ack       <= 3'b000;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_id    <= win_id;
                        cur_we    <= win_we;
                        mem_addr  <= win_addr;
                        mem_din   <= win_wdata;
                        mem_write <= win_we;
                        mem_read  <= !win_we;
                        state     <= ISSUE;
                        if (win_id == 2'd0) begin
                            if (!low_pending) begin
                                burst_cnt <= 4'd0;
                            end else if (burst_cnt != 4'hF) begin
                                burst_cnt <= burst_cnt + 4'd1;
                            end
                        end else begin
                            burst_cnt <= 4'd0;
                            rr_last2  <= (win_id == 2'd2);
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (to_fire) begin
                        ack   <= 3'b001 << cur_id;
                        state <= IDLE;
                        if (!cur_we) rdata <= DATA_W'(16'hDEAD);
                    end else if (mem_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!mem_busy) begin
                        ack   <= 3'b001 << cur_id;
                        state <= IDLE;
                        if (!cur_we) rdata <= mem_dout;
                    end else if (to_fire) begin
                        ack   <= 3'b001 << cur_id;
                        state <= IDLE;
                        if (!cur_we) rdata <= DATA_W'(16'hDEAD);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - directed and random checks of psram_arbiter against a rule-level arbitration model
module tb_psram_arbiter;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int VB = 4;

    logic          clk32  = 1'b0;
    logic          resetn = 1'b0;
    logic [2:0]    req    = 3'b000;
    logic [2:0]    we     = 3'b000;
    logic [AW-1:0] pa [3];
    logic [DW-1:0] pd [3];
    logic [2:0]    ack;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic          mem_busy = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit            en [3];
    bit            keep [3];
    bit            ovr [3];
    logic          ovr_we [3];
    logic [AW-1:0] ovr_a [3];
    logic [DW-1:0] ovr_d [3];
    bit            rnd_gap   = 1'b0;
    bit            keep_rand = 1'b0;
    bit            stuck     = 1'b0;
    bit            to_mode   = 1'b0;
    bit            fix_en    = 1'b0;
    int            fix_lat   = 1;
    logic [DW-1:0] fix_dout  = '0;

    int            nack = 0;
    int            nrd  = 0;
    int            fall_cyc = 0;
    int            st_cyc   = 0;
    logic [DW-1:0] last_dout = '0;
    int            gseq [$];
    bit            outstanding = 1'b0;
    int            cur = 0;
    logic          cur_we_m = 1'b0;
    int            vid_run = 0;
    int            last = 2;
    logic [DW-1:0] rd_exp = '0;
    int            t4 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    always #5 clk32 = ~clk32;
    always @(posedge clk32) cyc <= cyc + 1;

    psram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .VID_BURST_MAX(VB), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk32(clk32), .resetn(resetn), .req(req), .we(we),
        .addr0(pa[0]), .addr1(pa[1]), .addr2(pa[2]),
        .wdata0(pd[0]), .wdata1(pd[1]), .wdata2(pd[2]),
        .ack(ack), .rdata(rdata), .err(err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Fixed video priority capped at VB grants while host/aux wait; host/aux alternate.
    function automatic int pick(input logic [2:0] r);
        if (r[0] && !(vid_run >= VB && r[2:1] != 2'b00)) return 0;
        if (r[1] && r[2]) return (last == 1) ? 2 : 1;
        return r[1] ? 1 : 2;
    endfunction

    task automatic new_txn(input int p);
        we[p] = ovr[p] ? ovr_we[p] : 1'($urandom);
        pa[p] = ovr[p] ? ovr_a[p]  : AW'($urandom);
        pd[p] = ovr[p] ? ovr_d[p]  : DW'($urandom);
    endtask

    // Requesters: hold until ack, then either drop or chain a new request.
    initial begin
        logic [2:0] got;
        bit kp;
        for (int i = 0; i < 3; i++) begin
            pa[i] = '0;
            pd[i] = '0;
        end
        forever begin
            @(negedge clk32);
            got = ack;
            @(posedge clk32);
            #1;
            for (int p = 0; p < 3; p++) begin
                if (got[p]) begin
                    kp = keep_rand ? 1'($urandom_range(0, 1)) : keep[p];
                    if (en[p] && kp) new_txn(p);
                    else req[p] = 1'b0;
                end else if (!req[p] && en[p] && (!rnd_gap || $urandom_range(0, 3) == 0)) begin
                    req[p] = 1'b1;
                    new_txn(p);
                end
            end
        end
    end

    // CDC-side responder
    initial begin
        int lat;
        forever begin
            @(negedge clk32);
            if (resetn && (mem_read || mem_write)) begin
                @(posedge clk32);
                #1 mem_busy = 1'b1;
                if (stuck) begin
                    while (stuck) @(posedge clk32);
                    #1 mem_busy = 1'b0;
                    fall_cyc = cyc;
                end else begin
                    lat = fix_en ? fix_lat : int'($urandom_range(1, 6));
                    repeat (lat) @(posedge clk32);
                    #1;
                    mem_busy  = 1'b0;
                    mem_dout  = fix_en ? fix_dout : DW'($urandom);
                    last_dout = mem_dout;
                    fall_cyc  = cyc;
                end
            end
        end
    end

    // Scoreboard
    initial begin
        int e;
        int idle_run;
        logic [DW-1:0] rexp;
        logic [2:0] prev_req;
        idle_run = 0;
        prev_req = 3'b000;
        forever begin
            @(negedge clk32);
            if (!resetn) begin
                vid_run = 0; last = 2; rd_exp = '0; outstanding = 1'b0;
                idle_run = 0; prev_req = req;
                continue;
            end
            if (mem_read || mem_write) begin
                e = pick(prev_req);
                check("strobe_kind", 32'({mem_read, mem_write}), we[e] ? 32'd1 : 32'd2);
                check("strobe_addr", 32'(mem_addr), 32'(pa[e]));
                if (we[e]) check("strobe_din", 32'(mem_din), 32'(pd[e]));
                check("strobe_overlap", 32'(outstanding), 32'd0);
                if (e == 0) vid_run = (prev_req[2:1] != 2'b00) ? ((vid_run < 15) ? vid_run + 1 : 15) : 0;
                else begin
                    vid_run = 0;
                    last = e;
                end
                cur = e; cur_we_m = we[e]; st_cyc = cyc;
                gseq.push_back(e);
                if (!we[e]) nrd++;
                outstanding = 1'b1;
            end
            if (ack != 3'b000) begin
                check("ack_orphan", 32'(outstanding), 32'd1);
                check("ack_port", 32'(ack), 32'(3'b001 << cur));
                if (to_mode) begin
                    rexp = cur_we_m ? rd_exp : 16'hDEAD;
                    check("ack_lat_timeout", 32'(cyc), 32'(st_cyc + 17));
                    check("err_timeout", 32'(err), 32'd1);
                end else begin
                    rexp = cur_we_m ? rd_exp : last_dout;
                    check("ack_lat", 32'(cyc), 32'(fall_cyc + 1));
                    check("err_idle", 32'(err), 32'd0);
                end
                check("rdata", 32'(rdata), 32'(rexp));
                rd_exp = rexp;
                outstanding = 1'b0;
                nack++;
            end
            if (req != 3'b000 && !mem_read && !mem_write && ack == 3'b000 && !stuck) idle_run++;
            else idle_run = 0;
            if (idle_run > 200) begin
                check("stall", 32'(idle_run), 32'd0);
                idle_run = 0;
            end
            prev_req = req;
        end
    end

    task automatic wait_acks(input int n);
        int target = nack + n;
        int k = 0;
        while (nack < target && k < 3000) begin
            @(posedge clk32);
            k++;
        end
        if (nack < target) check("wait_acks", 32'(nack), 32'(target));
    endtask

    task automatic drain();
        int k = 0;
        for (int p = 0; p < 3; p++) begin
            en[p] = 1'b0;
            keep[p] = 1'b0;
        end
        keep_rand = 1'b0;
        while ((req != 3'b000 || mem_busy || outstanding) && k < 3000) begin
            @(posedge clk32);
            k++;
        end
        if (k >= 3000) check("drain", 32'(req), 32'd0);
        repeat (3) @(posedge clk32);
    endtask

    initial begin
        int base;
        int rd0;
        int a0;
        int k;
        for (int i = 0; i < 3; i++) begin
            ovr_we[i] = 1'b0;
            ovr_a[i]  = '0;
            ovr_d[i]  = '0;
        end

        repeat (3) @(posedge clk32);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk32) resetn = 1'b1;
        repeat (2) @(posedge clk32);

        // Single read on the host port
        fix_en = 1'b1; fix_lat = 6; fix_dout = 16'h1234;
        ovr[1] = 1'b1; ovr_we[1] = 1'b0; ovr_a[1] = 22'h00100;
        en[1] = 1'b1;
        wait_acks(1);
        en[1] = 1'b0;
        check("t1_rdata", 32'(rdata), 32'h1234);
        check("t1_addr", 32'(mem_addr), 32'h00100);
        drain();

        // Write on the aux port at the top address
        rd0 = nrd;
        ovr[2] = 1'b1; ovr_we[2] = 1'b1; ovr_a[2] = 22'h3FFFFF; ovr_d[2] = 16'hA5A5;
        en[2] = 1'b1;
        wait_acks(1);
        en[2] = 1'b0;
        check("t2_din", 32'(mem_din), 32'hA5A5);
        check("t2_rdata_held", 32'(rdata), 32'h1234);
        check("t2_no_read", 32'(nrd - rd0), 32'd0);
        drain();
        fix_en = 1'b0;
        for (int i = 0; i < 3; i++) ovr[i] = 1'b0;

        // Host and aux both continuous
        base = gseq.size();
        keep[1] = 1'b1; keep[2] = 1'b1;
        en[1] = 1'b1; en[2] = 1'b1;
        wait_acks(6);
        drain();
        for (int i = 0; i < 4; i++) check("t3_rr_order", 32'(gseq[base + i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // Video and host both continuous: burst cap lets host in every fifth grant
        base = gseq.size();
        keep[0] = 1'b1; keep[1] = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;
        wait_acks(12);
        drain();
        for (int i = 0; i < 10; i++) check("t4_burst_order", 32'(gseq[base + i]), 32'(t4[i]));

        // Reset while waiting for the CDC to finish
        stuck = 1'b1;
        ovr[1] = 1'b1; ovr_we[1] = 1'b0; ovr_a[1] = 22'h0ABCD;
        en[1] = 1'b1;
        k = 0;
        while (!mem_busy && k < 100) begin
            @(posedge clk32);
            k++;
        end
        if (!mem_busy) check("t5_busy_seen", 32'(mem_busy), 32'd1);
        repeat (2) @(posedge clk32);
        @(negedge clk32);
        #2 resetn = 1'b0;
        #1;
        a0 = nack;
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("t5_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_mem_din", 32'(mem_din), 32'd0);
        check("t5_rdata", 32'(rdata), 32'd0);
        repeat (3) @(posedge clk32);
        stuck = 1'b0;
        repeat (2) @(posedge clk32);
        check("t5_no_ack", 32'(nack), 32'(a0));
        @(negedge clk32) resetn = 1'b1;
        wait_acks(1);
        en[1] = 1'b0;
        drain();
        ovr[1] = 1'b0;

`ifdef PSRAM_ARB_TIMEOUT_EN
        // Busy stuck high: watchdog completes the read with an error
        stuck = 1'b1;
        to_mode = 1'b1;
        en[2] = 1'b1;
        ovr[2] = 1'b1; ovr_we[2] = 1'b0; ovr_a[2] = 22'h01234;
        wait_acks(1);
        en[2] = 1'b0;
        to_mode = 1'b0;
        check("t6_rdata_dead", 32'(rdata), 32'hDEAD);
        stuck = 1'b0;
        drain();
        ovr[2] = 1'b0;
`endif

        // Random mix on all ports
        rnd_gap = 1'b1;
        keep_rand = 1'b1;
        for (int p = 0; p < 3; p++) en[p] = 1'b1;
        wait_acks(300);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
